lsu_dm_master: RTL and testbench

Load/store initiator between the MEM stage and dm_1k. It accepts one load or store per handshake and drives dm_1k's addr/din/WriteEn/sel. It extends byte loads to the requested signedness. Word accesses at unaligned addresses, which dm_1k does not protect against, are split into four little-endian byte beats. A single response pulse returns load data or a store acknowledge.

---
 rtl/lsu_dm_master_pkg.sv | 37 +++
 rtl/lsu_dm_master.sv | 130 +++++++++++++
 tb/tb_lsu_dm_master.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_dm_master_pkg.sv
// Shared opcode, memory-select and state encodings for the LSU to dm_1k initiator,
// plus small opcode-classification helpers.
package lsu_dm_master_pkg;

  localparam logic [2:0] LSU_LW  = 3'd0;
  localparam logic [2:0] LSU_LB  = 3'd1;
  localparam logic [2:0] LSU_LBU = 3'd2;
  localparam logic [2:0] LSU_SW  = 3'd3;
  localparam logic [2:0] LSU_SB  = 3'd4;

  localparam logic DM_WORD = 1'b0;
  localparam logic DM_BYTE = 1'b1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_SPLIT  = 2'd2;

  function automatic logic is_legal(input logic [2:0] op);
    return op <= LSU_SB;
  endfunction

  function automatic logic is_word(input logic [2:0] op);
    return (op == LSU_LW) || (op == LSU_SW);
  endfunction

  function automatic logic is_load(input logic [2:0] op);
    return (op == LSU_LW) || (op == LSU_LB) || (op == LSU_LBU);
  endfunction

  // dm_1k already sign-extends byte reads, so only LBU needs rework.
  function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [31:0] dout);
    return (op == LSU_LBU) ? {24'b0, dout[7:0]} : dout;
  endfunction

endpackage

// File: rtl/lsu_dm_master.sv
// Load/store initiator driving dm_1k: one request per handshake, unaligned words split
// into four little-endian byte beats, single-cycle response pulse with data or error.
module lsu_dm_master
  import lsu_dm_master_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  input  logic [31:0]       dm_dout,
  output logic              dm_we,
  output logic              dm_sel
);

  state_t            state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [23:0]       asm_q;
  logic [1:0]        beat;

  logic accept;
  logic req_unaligned;
  logic req_bad;
  logic cur_load;
  logic cur_word;

  assign req_ready     = (state == ST_IDLE) && !rst;
  assign accept        = req_valid && req_ready;
  assign req_unaligned = (req_addr[1:0] != 2'b00);
  assign req_bad       = !is_legal(req_op) || (is_word(req_op) && req_unaligned && !SPLIT_EN);
  assign cur_load      = is_load(op_q);
  assign cur_word      = is_word(op_q);

  // Memory-side drive is gated by rst so an aborted split cannot commit another beat.
  always_comb begin
    dm_addr = '0;
    dm_din  = '0;
    dm_we   = 1'b0;
    dm_sel  = DM_WORD;
    if (!rst) begin
      case (state)
        ST_ACCESS: begin
          dm_addr = addr_q;
          dm_sel  = cur_word ? DM_WORD : DM_BYTE;
          dm_we   = !cur_load;
          dm_din  = wdata_q;
        end
        ST_SPLIT: begin
          dm_addr = addr_q + ADDR_W'(beat);
          dm_sel  = DM_BYTE;
          dm_we   = !cur_load;
          dm_din  = {24'b0, wdata_q[{beat, 3'b000} +: 8]};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      asm_q      <= 24'd0;
      beat       <= 2'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            beat    <= 2'd0;
            if (req_bad) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else if (is_word(req_op) && req_unaligned) begin
              state <= ST_SPLIT;
            end else begin
              state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b1;
          resp_rdata <= cur_load ? load_extend(op_q, dm_dout) : 32'd0;
        end
        ST_SPLIT: begin
          // Lower bytes assemble privately so resp_rdata holds the previous response meanwhile.
          if (cur_load) begin
            case (beat)
              2'd0:    asm_q[7:0]   <= dm_dout[7:0];
              2'd1:    asm_q[15:8]  <= dm_dout[7:0];
              2'd2:    asm_q[23:16] <= dm_dout[7:0];
              default: ;
            endcase
          end
          beat <= beat + 2'd1;
          if (beat == 2'd3) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b1;
            resp_rdata <= cur_load ? {dm_dout[7:0], asm_q} : 32'd0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dm_master.sv
// Bench for lsu_dm_master: byte-array dm_1k stand-in, byte-level reference model,
// per-cycle response checker, directed scenarios and a randomized run.
module tb_lsu_dm_master;
  import lsu_dm_master_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [9:0]  req_addr = 10'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;
  logic        dm_we;
  logic        dm_sel;

  logic        req_valid1 = 1'b0;
  logic        req_ready1;
  logic [2:0]  req_op1 = 3'd0;
  logic [9:0]  req_addr1 = 10'd0;
  logic [31:0] req_wdata1 = 32'd0;
  logic        resp_valid1;
  logic [31:0] resp_rdata1;
  logic        resp_err1;
  logic [9:0]  dm_addr1;
  logic [31:0] dm_din1;
  logic [31:0] dm_dout1;
  logic        dm_we1;
  logic        dm_sel1;

  assign dm_dout1 = 32'hFFFF_FF80;

  lsu_dm_master #(.ADDR_W(10), .SPLIT_EN(1'b1)) u0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout),
    .dm_we(dm_we), .dm_sel(dm_sel)
  );

  lsu_dm_master #(.ADDR_W(10), .SPLIT_EN(1'b0)) u1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_op(req_op1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_err(resp_err1),
    .dm_addr(dm_addr1), .dm_din(dm_din1), .dm_dout(dm_dout1),
    .dm_we(dm_we1), .dm_sel(dm_sel1)
  );

  // dm_1k stand-in: little-endian bytes, combinational read, byte reads sign-extended.
  logic [7:0] dm_mem [0:1023] = '{default: 8'h00};

  always @(posedge clk) begin
    if (dm_we) begin
      if (dm_sel == DM_WORD) begin
        for (int k = 0; k < 4; k++) dm_mem[dm_addr + 10'(k)] <= dm_din[8*k +: 8];
      end else begin
        dm_mem[dm_addr] <= dm_din[7:0];
      end
    end
  end

  always_comb begin
    if (dm_sel == DM_WORD)
      dm_dout = {dm_mem[dm_addr + 10'd3], dm_mem[dm_addr + 10'd2],
                 dm_mem[dm_addr + 10'd1], dm_mem[dm_addr]};
    else
      dm_dout = {{24{dm_mem[dm_addr][7]}}, dm_mem[dm_addr]};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: memory as plain bytes, each request resolved at accept time.
  logic [7:0] ref_mem [0:1023] = '{default: 8'h00};

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t q0[$];

  task automatic model(input logic [2:0] op, input int addr, input logic [31:0] wd,
                       output int lat, output logic err, output logic [31:0] rd);
    logic       word;
    logic [7:0] b;
    err  = 1'b0;
    rd   = 32'd0;
    word = (op == LSU_LW) || (op == LSU_SW);
    b    = ref_mem[addr % 1024];
    if (op > LSU_SB) begin
      err = 1'b1;
      lat = 1;
    end else begin
      lat = (word && (addr % 4 != 0)) ? 5 : 2;
      case (op)
        LSU_LW:  for (int k = 0; k < 4; k++) rd[8*k +: 8] = ref_mem[(addr + k) % 1024];
        LSU_LB:  rd = {{24{b[7]}}, b};
        LSU_LBU: rd = {24'd0, b};
        LSU_SW:  for (int k = 0; k < 4; k++) ref_mem[(addr + k) % 1024] = wd[8*k +: 8];
        default: ref_mem[addr % 1024] = wd[7:0];
      endcase
    end
  endtask

  logic [31:0] last_rdata = 32'd0;
  logic        last_err = 1'b0;
  int          resp_cnt = 0;
  logic        trace_on = 1'b0;
  int          trace_addr[$];
  int          nready_cnt = 0;

  // Per-cycle compare of the SPLIT_EN=1 instance against the model's expected responses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0 && q0[0].due == cyc) begin
        e = q0.pop_front();
        chk("resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_rdata", resp_rdata, e.rdata);
      end else begin
        chk("spurious_resp", {31'd0, resp_valid}, 32'd0);
      end
      chk("we_in_idle", {31'd0, dm_we && req_ready}, 32'd0);
      chk("u1_we", {31'd0, dm_we1}, 32'd0);
      if (resp_valid) begin
        last_rdata = resp_rdata;
        last_err   = resp_err;
        resp_cnt++;
      end
      if (trace_on && !rst) begin
        if (dm_sel == DM_BYTE) trace_addr.push_back(int'(dm_addr));
        if (!req_ready) nready_cnt++;
      end
    end
  end

  task automatic do_req(input logic [2:0] op, input int addr, input logic [31:0] wd,
                        input logic track);
    int          n;
    int          lat;
    logic        err;
    logic [31:0] rd;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = 10'(addr);
    req_wdata = wd;
    if (track) begin
      model(op, addr, wd, lat, err, rd);
      q0.push_back('{cyc + lat, err, rd});
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (q0.size() != 0 && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("resp_timeout", q0.size(), 0);
  endtask

  task automatic req_chk(input logic [2:0] op, input int addr, input logic [31:0] wd,
                         input string nm, input logic want_err, input logic [31:0] want);
    int c0;
    c0 = resp_cnt;
    do_req(op, addr, wd, 1'b1);
    wait_resp();
    chk({nm, "_cnt"}, resp_cnt, c0 + 1);
    chk({nm, "_err"}, {31'd0, last_err}, {31'd0, want_err});
    chk({nm, "_data"}, last_rdata, want);
  endtask

  task automatic do1(input logic [2:0] op, input int addr, input int lat, input logic err,
                     input logic [31:0] rd, input string nm);
    @(negedge clk);
    chk({nm, "_ready"}, {31'd0, req_ready1}, 32'd1);
    req_valid1 = 1'b1;
    req_op1    = op;
    req_addr1  = 10'(addr);
    req_wdata1 = 32'h5A5A_5A5A;
    @(posedge clk);
    #1 req_valid1 = 1'b0;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      chk({nm, "_early"}, {31'd0, resp_valid1}, 32'd0);
    end
    @(negedge clk);
    chk({nm, "_valid"}, {31'd0, resp_valid1}, 32'd1);
    chk({nm, "_err"}, {31'd0, resp_err1}, {31'd0, err});
    chk({nm, "_data"}, resp_rdata1, rd);
  endtask

  initial begin
    int diffs;
    int op_r;
    int addr_r;

    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_we", {31'd0, dm_we}, 32'd0);
    chk("rst_addr", {22'd0, dm_addr}, 32'd0);
    chk("rst_din", dm_din, 32'd0);
    chk("rst_sel", {31'd0, dm_sel}, {31'd0, DM_WORD});
    rst = 1'b0;
    #1 chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    req_chk(LSU_SW, 0, 32'h1234_5678, "sw0", 1'b0, 32'd0);
    req_chk(LSU_LW, 0, 32'd0, "lw0", 1'b0, 32'h1234_5678);
    req_chk(LSU_LB, 0, 32'd0, "lb0", 1'b0, 32'h0000_0078);

    req_chk(LSU_SB, 0, 32'hFFFF_FF87, "sb0", 1'b0, 32'd0);
    req_chk(LSU_LB, 0, 32'd0, "lb0_neg", 1'b0, 32'hFFFF_FF87);
    req_chk(LSU_LBU, 0, 32'd0, "lbu0", 1'b0, 32'h0000_0087);
    req_chk(LSU_LW, 0, 32'd0, "lw0_merged", 1'b0, 32'h1234_5687);

    trace_on = 1'b1;
    trace_addr.delete();
    nready_cnt = 0;
    req_chk(LSU_LW, 1, 32'd0, "lw1_split", 1'b0, 32'h0012_3456);
    trace_on = 1'b0;
    chk("split_beats", trace_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < trace_addr.size()) chk("split_addr", trace_addr[i], i + 1);
    end
    chk("split_not_ready", nready_cnt, 4);

    req_chk(LSU_SW, 0, 32'd0, "sw0_clear", 1'b0, 32'd0);
    req_chk(LSU_SW, 'h3FE, 32'hAABB_CCDD, "sw_wrap", 1'b0, 32'd0);
    req_chk(LSU_LW, 0, 32'd0, "lw_wrap", 1'b0, 32'h0000_AABB);
    req_chk(LSU_LB, 'h3FE, 32'd0, "lb_3fe", 1'b0, 32'hFFFF_FFDD);
    req_chk(LSU_LBU, 'h3FF, 32'd0, "lbu_3ff", 1'b0, 32'h0000_00CC);

    // Abort a split store during beat 1: only beat 0 reaches memory.
    do_req(LSU_SW, 'h101, 32'hAABB_CCDD, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_we", {31'd0, dm_we}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
    ref_mem['h101] = 8'hDD;
    repeat (6) @(negedge clk);
    req_chk(LSU_LW, 'h100, 32'd0, "abort_lw100", 1'b0, 32'h0000_DD00);
    req_chk(LSU_LBU, 'h104, 32'd0, "abort_lb104", 1'b0, 32'd0);

    req_chk(3'b111, 5, 32'hFFFF_FFFF, "illegal_op", 1'b1, 32'd0);

    do1(LSU_LW, 2, 1, 1'b1, 32'd0, "u1_lw_unal");
    do1(LSU_SW, 1, 1, 1'b1, 32'd0, "u1_sw_unal");
    do1(3'd6, 0, 1, 1'b1, 32'd0, "u1_illegal");
    do1(LSU_LW, 0, 2, 1'b0, 32'hFFFF_FF80, "u1_lw");
    do1(LSU_LBU, 4, 2, 1'b0, 32'h0000_0080, "u1_lbu");
    do1(LSU_LB, 7, 2, 1'b0, 32'hFFFF_FF80, "u1_lb");

    for (int i = 0; i < 400; i++) begin
      op_r = int'($urandom_range(0, 5));
      if (op_r == 5) op_r = int'($urandom_range(5, 7));
      case ($urandom_range(0, 2))
        0:       addr_r = int'($urandom_range(0, 15));
        1:       addr_r = 1024 - int'($urandom_range(1, 6));
        default: addr_r = int'($urandom_range(0, 1023));
      endcase
      do_req(3'(op_r), addr_r, $urandom, 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    wait_resp();

    diffs = 0;
    for (int i = 0; i < 1024; i++) if (dm_mem[i] !== ref_mem[i]) diffs++;
    chk("mem_image", diffs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
